// File: rtl/qddc_tune_ctrl.sv
// qddc_tune_ctrl: DDC retune sequencer.
// Accepts NCO/IQ settings on a valid/ready port and applies them on an
// output-sample boundary. It can pulse a datapath reset, then blanks
// data_valid until the CIC decimators have flushed stale samples.
// Ports:
//   clk, reset           clock, synchronous active-high reset
//   cfg_valid/cfg_ready  configuration handshake (ready only in IDLE)
//   cfg_freq/dir/ns_en/swap/flush  requested settings
//   sample_stb           one pulse per DDC output sample
//   lo_freq/lo_dir/lo_ns_en/iq_swap  applied settings
//   dsp_reset            datapath reset pulse for flush retunes
//   data_valid, busy     output qualification and sequencer status
//   retune_cnt           number of applied configurations (wraps)
module qddc_tune_ctrl #(
    parameter int FSZ            = 31,
    parameter int SETTLE_SAMPLES = 5,
    parameter int RST_CYCLES     = 2
) (
    input  logic           clk,
    input  logic           reset,
    input  logic           cfg_valid,
    output logic           cfg_ready,
    input  logic [FSZ-1:0] cfg_freq,
    input  logic           cfg_dir,
    input  logic           cfg_ns_en,
    input  logic           cfg_swap,
    input  logic           cfg_flush,
    input  logic           sample_stb,
    output logic [FSZ-1:0] lo_freq,
    output logic           lo_dir,
    output logic           lo_ns_en,
    output logic           iq_swap,
    output logic           dsp_reset,
    output logic           data_valid,
    output logic           busy,
    output logic [15:0]    retune_cnt
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ARM,
        S_FLUSH,
        S_SETTLE
    } state_t;

    localparam logic [7:0] SETTLE_LAST = 8'(SETTLE_SAMPLES);
    localparam logic [7:0] RST_LAST    = 8'(RST_CYCLES - 1);

    state_t         state_q, state_d;
    logic [7:0]     cnt_q, cnt_d;

    logic [FSZ-1:0] sh_freq_q, sh_freq_d;
    logic           sh_dir_q, sh_dir_d;
    logic           sh_ns_q, sh_ns_d;
    logic           sh_swap_q, sh_swap_d;
    logic           sh_flush_q, sh_flush_d;

    logic [FSZ-1:0] lo_freq_d;
    logic           lo_dir_d, lo_ns_en_d, iq_swap_d;
    logic           dsp_reset_d, data_valid_d;
    logic           cfg_ready_d, busy_d;
    logic [15:0]    retune_cnt_d;

    always_ff @(posedge clk) begin
        if (reset) begin
            // Startup behaves like a settle phase so the CICs flush
            // whatever they held before reset.
            state_q    <= S_SETTLE;
            cnt_q      <= '0;
            sh_freq_q  <= '0;
            sh_dir_q   <= 1'b0;
            sh_ns_q    <= 1'b0;
            sh_swap_q  <= 1'b0;
            sh_flush_q <= 1'b0;
            lo_freq    <= '0;
            lo_dir     <= 1'b0;
            lo_ns_en   <= 1'b0;
            iq_swap    <= 1'b0;
            dsp_reset  <= 1'b0;
            data_valid <= 1'b0;
            cfg_ready  <= 1'b0;
            busy       <= 1'b1;
            retune_cnt <= '0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            sh_freq_q  <= sh_freq_d;
            sh_dir_q   <= sh_dir_d;
            sh_ns_q    <= sh_ns_d;
            sh_swap_q  <= sh_swap_d;
            sh_flush_q <= sh_flush_d;
            lo_freq    <= lo_freq_d;
            lo_dir     <= lo_dir_d;
            lo_ns_en   <= lo_ns_en_d;
            iq_swap    <= iq_swap_d;
            dsp_reset  <= dsp_reset_d;
            data_valid <= data_valid_d;
            cfg_ready  <= cfg_ready_d;
            busy       <= busy_d;
            retune_cnt <= retune_cnt_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        sh_freq_d    = sh_freq_q;
        sh_dir_d     = sh_dir_q;
        sh_ns_d      = sh_ns_q;
        sh_swap_d    = sh_swap_q;
        sh_flush_d   = sh_flush_q;
        lo_freq_d    = lo_freq;
        lo_dir_d     = lo_dir;
        lo_ns_en_d   = lo_ns_en;
        iq_swap_d    = iq_swap;
        dsp_reset_d  = dsp_reset;
        data_valid_d = data_valid;
        retune_cnt_d = retune_cnt;

        unique case (state_q)
            S_IDLE: begin
                // A strobe in the accept cycle is deliberately ignored.
                if (cfg_valid && cfg_ready) begin
                    sh_freq_d  = cfg_freq;
                    sh_dir_d   = cfg_dir;
                    sh_ns_d    = cfg_ns_en;
                    sh_swap_d  = cfg_swap;
                    sh_flush_d = cfg_flush;
                    state_d    = S_ARM;
                end
            end
            S_ARM: begin
                if (sample_stb) begin
                    lo_freq_d    = sh_freq_q;
                    lo_dir_d     = sh_dir_q;
                    lo_ns_en_d   = sh_ns_q;
                    iq_swap_d    = sh_swap_q;
                    data_valid_d = 1'b0;
                    retune_cnt_d = retune_cnt + 16'd1;
                    cnt_d        = '0;
                    if (sh_flush_q) begin
                        state_d     = S_FLUSH;
                        dsp_reset_d = 1'b1;
                    end else begin
                        state_d = S_SETTLE;
                    end
                end
            end
            S_FLUSH: begin
                // Strobes are not counted while the datapath is held.
                if (cnt_q == RST_LAST) begin
                    state_d     = S_SETTLE;
                    dsp_reset_d = 1'b0;
                    cnt_d       = '0;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            S_SETTLE: begin
                if (sample_stb) begin
                    if (cnt_q + 8'd1 == SETTLE_LAST) begin
                        state_d      = S_IDLE;
                        data_valid_d = 1'b1;
                        cnt_d        = '0;
                    end else begin
                        cnt_d = cnt_q + 8'd1;
                    end
                end
            end
        endcase

        cfg_ready_d = (state_d == S_IDLE);
        busy_d      = (state_d != S_IDLE);
    end

endmodule
